// File: rtl/pu_dispatch_pkg.sv
// Shared definitions for the PU dispatch stage: opcode values, instruction
// field positions, compare selector codes and FSM state encodings.
package pu_dispatch_pkg;

  localparam int INSTR_W  = 32;
  localparam int OPCODE_W = 6;
  localparam int REG_W    = 5;
  localparam int CMP_W    = 4;

  // Instruction word layout
  localparam int OPCODE_MSB = 31;
  localparam int REGD_LSB   = 21;
  localparam int REGA_LSB   = 16;
  localparam int REGB_LSB   = 11;
  localparam int CMP_LSB    = 0;

  typedef enum logic [OPCODE_W-1:0] {
    OPCODE_NOP  = 6'd0,
    OPCODE_SUB  = 6'd1,
    OPCODE_ADD  = 6'd2,
    OPCODE_ICMP = 6'd3
  } opcode_e;

  // Compare selector codes carried in the cmp_op field
  localparam logic [CMP_W-1:0] FLAG_INDEX_EQ  = 4'd0;
  localparam logic [CMP_W-1:0] FLAG_INDEX_NE  = 4'd1;
  localparam logic [CMP_W-1:0] FLAG_INDEX_LTU = 4'd2;
  localparam logic [CMP_W-1:0] FLAG_INDEX_LTS = 4'd3;
  localparam logic [CMP_W-1:0] FLAG_INDEX_GEU = 4'd4;
  localparam logic [CMP_W-1:0] FLAG_INDEX_GES = 4'd5;

  // Dispatch FSM encodings
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_STALL = 2'd2;
  localparam logic [1:0] ST_TRAP  = 2'd3;

endpackage

// File: rtl/pu_dispatch_if.sv
// Fetch-side and PU-chain-side signals of the dispatch stage.
// master: the dispatch stage itself; slave: its environment (fetch + PUs).
interface pu_dispatch_if
  import pu_dispatch_pkg::*;
#(
  parameter int OPTION_OPCODE_WIDTH = OPCODE_W,
  parameter int OPTION_CNT_WIDTH    = 32
);
  logic [INSTR_W-1:0]             i_instr;
  logic                           i_instr_valid;
  logic                           o_instr_ready;
  logic [OPTION_OPCODE_WIDTH-1:0] o_opcode;
  logic [REG_W-1:0]               o_rega;
  logic [REG_W-1:0]               o_regb;
  logic [REG_W-1:0]               o_regd;
  logic [CMP_W-1:0]               o_cmp_op;
  logic                           o_chain_ack;
  logic                           i_chain_ack;
  logic                           i_chain_busy;
  logic                           o_retire;
  logic [OPTION_CNT_WIDTH-1:0]    o_retire_cnt;
  logic                           o_trap;
  logic [OPTION_OPCODE_WIDTH-1:0] o_trap_opcode;
  logic                           i_trap_clear;

  modport master (
    input  i_instr, i_instr_valid, i_chain_ack, i_chain_busy, i_trap_clear,
    output o_instr_ready, o_opcode, o_rega, o_regb, o_regd, o_cmp_op,
           o_chain_ack, o_retire, o_retire_cnt, o_trap, o_trap_opcode
  );

  modport slave (
    output i_instr, i_instr_valid, i_chain_ack, i_chain_busy, i_trap_clear,
    input  o_instr_ready, o_opcode, o_rega, o_regb, o_regd, o_cmp_op,
           o_chain_ack, o_retire, o_retire_cnt, o_trap, o_trap_opcode
  );

endinterface

// File: rtl/pu_instr_fifo.sv
// Circular synchronous FIFO buffering instruction words ahead of the issue slot.
// A push while full is accepted only if a pop happens in the same cycle.
module pu_instr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int NW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign full    = (count == NW'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + NW'(1);
        2'b01:   count <= count - NW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array, data only
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/pu_dispatch.sv
// Issue stage for the PU chain: buffers fetched words, holds one in the issue
// slot, broadcasts its decoded fields to every PU and retires it when a PU
// claims it through the unique-ack chain. An unclaimed opcode halts dispatch
// in TRAP until the environment clears it.
module pu_dispatch
  import pu_dispatch_pkg::*;
#(
  parameter int OPTION_OPCODE_WIDTH = OPCODE_W,
  parameter int OPTION_FIFO_DEPTH   = 4,
  parameter int OPTION_CNT_WIDTH    = 32
) (
  input logic           i_clk,
  input logic           i_rst_n,
  pu_dispatch_if.master bus
);

  logic [1:0]                       state;
  logic [1:0]                       nxt_state;
  logic [INSTR_W-1:0]               slot_instr;
  logic [INSTR_W-1:0]               fifo_dout;
  logic                             fifo_full;
  logic                             fifo_empty;
  logic [$clog2(OPTION_FIFO_DEPTH):0] fifo_count_unused;
  logic                             push;
  logic                             load;
  logic                             retire;
  logic                             drop;
  logic                             fld_en;
  logic [OPTION_OPCODE_WIDTH-1:0]   slot_opcode;
  logic [OPTION_OPCODE_WIDTH-1:0]   trap_opcode;
  logic [OPTION_CNT_WIDTH-1:0]      retire_cnt;
  logic                             unused_slot_bits;

  assign push = bus.i_instr_valid && !fifo_full;

  pu_instr_fifo #(
    .DEPTH (OPTION_FIFO_DEPTH),
    .WIDTH (INSTR_W)
  ) u_fifo (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .push  (push),
    .din   (bus.i_instr),
    .pop   (load),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count_unused)
  );

  assign slot_opcode = slot_instr[OPCODE_MSB -: OPTION_OPCODE_WIDTH];

  // Next-state, slot load and retire/discard decisions; trap_clear beats busy beats ack
  always_comb begin
    nxt_state = state;
    load      = 1'b0;
    retire    = 1'b0;
    drop      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          load      = 1'b1;
          nxt_state = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (slot_opcode == '0)          retire    = 1'b1;
        else if (bus.i_chain_busy)      nxt_state = ST_STALL;
        else if (bus.i_chain_ack)       retire    = 1'b1;
        else                            nxt_state = ST_TRAP;
      end
      ST_STALL: begin
        if (!bus.i_chain_busy) retire = 1'b1;
      end
      ST_TRAP: begin
        if (bus.i_trap_clear) drop = 1'b1;
      end
      default: nxt_state = ST_IDLE;
    endcase
    // Leaving the slot: refill straight from the buffer when possible
    if (retire || drop) begin
      if (!fifo_empty) begin
        load      = 1'b1;
        nxt_state = ST_ISSUE;
      end else begin
        nxt_state = ST_IDLE;
      end
    end
  end

  // Control state: FSM, retire counter and captured trap opcode
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= ST_IDLE;
      retire_cnt  <= '0;
      trap_opcode <= '0;
    end else begin
      state <= nxt_state;
      if (retire) retire_cnt <= retire_cnt + OPTION_CNT_WIDTH'(1);
      if (state == ST_ISSUE && nxt_state == ST_TRAP) trap_opcode <= slot_opcode;
      else if (drop)                                 trap_opcode <= '0;
    end
  end

  // Issue slot data; only meaningful while the FSM says the slot is live
  always_ff @(posedge i_clk) begin
    if (load) slot_instr <= fifo_dout;
  end

  // Fields reach the PUs only in ISSUE/STALL; TRAP and IDLE present a NOP
  assign fld_en = (state == ST_ISSUE) || (state == ST_STALL);

  assign bus.o_opcode      = fld_en ? slot_opcode : '0;
  assign bus.o_regd        = fld_en ? slot_instr[REGD_LSB +: REG_W] : '0;
  assign bus.o_rega        = fld_en ? slot_instr[REGA_LSB +: REG_W] : '0;
  assign bus.o_regb        = fld_en ? slot_instr[REGB_LSB +: REG_W] : '0;
  assign bus.o_cmp_op      = fld_en ? slot_instr[CMP_LSB +: CMP_W] : '0;
  assign bus.o_chain_ack   = 1'b0;
  assign bus.o_instr_ready = !fifo_full;
  assign bus.o_retire      = retire;
  assign bus.o_retire_cnt  = retire_cnt;
  assign bus.o_trap        = (state == ST_TRAP);
  assign bus.o_trap_opcode = trap_opcode;

  // Word bits between regb and cmp_op carry nothing for the PUs
  assign unused_slot_bits = ^slot_instr[REGB_LSB-1:CMP_LSB+CMP_W];

endmodule

// File: tb/tb_pu_dispatch.sv
// Directed bench for pu_dispatch: per-cycle vector table plus hand sequences
// for power-on and asynchronous mid-traffic reset. Counter built 4 bits wide
// so wrap-around is reachable.
module tb_pu_dispatch;
  import pu_dispatch_pkg::*;

  localparam int OW = 6;
  localparam int CW = 4;

  localparam logic [31:0] W_ADD  = 32'h0861_1000; // ADD r3 = r1 + r2
  localparam logic [31:0] W_ADD2 = 32'h08E8_4800; // ADD r7 = r8 + r9
  localparam logic [31:0] W_ICMP = 32'h0C04_2802; // ICMP r4, r5, cmp 2
  localparam logic [31:0] W_BAD  = 32'hFC00_0000; // opcode 0x3F, nobody claims

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pu_dispatch_if #(.OPTION_OPCODE_WIDTH(OW), .OPTION_CNT_WIDTH(CW)) bus ();

  pu_dispatch #(
    .OPTION_OPCODE_WIDTH (OW),
    .OPTION_FIFO_DEPTH   (4),
    .OPTION_CNT_WIDTH    (CW)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  typedef struct {
    logic          v;
    logic [31:0]   instr;
    logic          ack;
    logic          busy;
    logic          clr;
    logic          rdy;
    logic [31:0]   ew;   // word whose fields must be on the PU bus (0 = NOP)
    logic          ret;
    logic [CW-1:0] cnt;
    logic          trap;
    logic [OW-1:0] top;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic vec_t mk(input int v, input int instr, input int ack, input int busy,
                              input int clr, input int rdy, input int ew, input int ret,
                              input int cnt, input int trap, input int top);
    vec_t r;
    r.v     = 1'(v);
    r.instr = 32'(instr);
    r.ack   = 1'(ack);
    r.busy  = 1'(busy);
    r.clr   = 1'(clr);
    r.rdy   = 1'(rdy);
    r.ew    = 32'(ew);
    r.ret   = 1'(ret);
    r.cnt   = CW'(cnt);
    r.trap  = 1'(trap);
    r.top   = OW'(top);
    return r;
  endfunction

  function automatic logic [31:0] nop_w(input int k);
    return 32'(k) << 16;   // NOP tagged through the rega field
  endfunction

  function automatic logic [31:0] sub_w(input int k);
    return 32'h0400_0000 | (32'(k) << 16);
  endfunction

  function automatic string fmt(input logic [38:0] p);
    return $sformatf("rdy=%b op=%h rd=%0d ra=%0d rb=%0d cmp=%h ret=%b cnt=%0d trap=%b top=%h cack=%b",
                     p[38], p[37:32], p[31:27], p[26:22], p[21:17], p[16:13], p[12],
                     p[11:8], p[7], p[6:1], p[0]);
  endfunction

  task automatic drive(input logic v, input logic [31:0] instr, input logic ack,
                       input logic busy, input logic clr);
    bus.i_instr_valid = v;
    bus.i_instr       = instr;
    bus.i_chain_ack   = ack;
    bus.i_chain_busy  = busy;
    bus.i_trap_clear  = clr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs(input string name, input logic rdy, input logic [31:0] ew,
                               input logic ret, input logic [CW-1:0] cnt, input logic trap,
                               input logic [OW-1:0] top);
    logic [38:0] act;
    logic [38:0] exp_v;
    act   = {bus.o_instr_ready, bus.o_opcode, bus.o_regd, bus.o_rega, bus.o_regb,
             bus.o_cmp_op, bus.o_retire, bus.o_retire_cnt, bus.o_trap, bus.o_trap_opcode,
             bus.o_chain_ack};
    exp_v = {rdy, ew[31:26], ew[25:21], ew[20:16], ew[15:11], ew[3:0], ret, cnt, trap,
             top, 1'b0};
    n_vec++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %s | want %s", name, fmt(act), fmt(exp_v));
    end
  endtask

  initial begin
    // ADD with ack held: fields two cycles after the push, then retire
    vecs.push_back(mk(1, W_ADD, 1, 0, 0,  1, 0,     0, 0, 0, 0));
    vecs.push_back(mk(0, 0,     1, 0, 0,  1, 0,     0, 0, 0, 0));
    vecs.push_back(mk(0, 0,     1, 0, 0,  1, W_ADD, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0,     1, 0, 0,  1, 0,     0, 1, 0, 0));
    // Five words while the first is held busy: buffer fills, then 1 retire/cycle
    vecs.push_back(mk(1, sub_w(1), 1, 1, 0,  1, 0,        0, 1, 0, 0));
    vecs.push_back(mk(1, sub_w(2), 1, 1, 0,  1, 0,        0, 1, 0, 0));
    vecs.push_back(mk(1, sub_w(3), 1, 1, 0,  1, sub_w(1), 0, 1, 0, 0));
    vecs.push_back(mk(1, sub_w(4), 1, 1, 0,  1, sub_w(1), 0, 1, 0, 0));
    vecs.push_back(mk(1, sub_w(5), 1, 1, 0,  1, sub_w(1), 0, 1, 0, 0));
    vecs.push_back(mk(0, 0,        1, 1, 0,  0, sub_w(1), 0, 1, 0, 0));
    vecs.push_back(mk(0, 0,        1, 0, 0,  0, sub_w(1), 1, 1, 0, 0));
    vecs.push_back(mk(0, 0,        1, 0, 0,  1, sub_w(2), 1, 2, 0, 0));
    vecs.push_back(mk(0, 0,        1, 0, 0,  1, sub_w(3), 1, 3, 0, 0));
    vecs.push_back(mk(0, 0,        1, 0, 0,  1, sub_w(4), 1, 4, 0, 0));
    vecs.push_back(mk(0, 0,        1, 0, 0,  1, sub_w(5), 1, 5, 0, 0));
    vecs.push_back(mk(0, 0,        1, 0, 0,  1, 0,        0, 6, 0, 0));
    // ICMP held busy 3 cycles: fields stable 4 cycles, single retire at busy fall
    vecs.push_back(mk(1, W_ICMP, 1, 0, 0,  1, 0,      0, 6, 0, 0));
    vecs.push_back(mk(0, 0,      1, 0, 0,  1, 0,      0, 6, 0, 0));
    vecs.push_back(mk(0, 0,      1, 1, 0,  1, W_ICMP, 0, 6, 0, 0));
    vecs.push_back(mk(0, 0,      0, 1, 0,  1, W_ICMP, 0, 6, 0, 0));
    vecs.push_back(mk(0, 0,      0, 1, 0,  1, W_ICMP, 0, 6, 0, 0));
    vecs.push_back(mk(0, 0,      0, 0, 0,  1, W_ICMP, 1, 6, 0, 0));
    vecs.push_back(mk(0, 0,      0, 0, 0,  1, 0,      0, 7, 0, 0));
    // Unclaimed 0x3F traps; clear drops it and the queued ADD issues
    vecs.push_back(mk(1, W_BAD,  0, 0, 0,  1, 0,      0, 7, 0, 0));
    vecs.push_back(mk(1, W_ADD2, 0, 0, 0,  1, 0,      0, 7, 0, 0));
    vecs.push_back(mk(0, 0,      0, 0, 0,  1, W_BAD,  0, 7, 0, 0));
    vecs.push_back(mk(0, 0,      0, 0, 0,  1, 0,      0, 7, 1, 'h3F));
    vecs.push_back(mk(0, 0,      0, 0, 0,  1, 0,      0, 7, 1, 'h3F));
    vecs.push_back(mk(0, 0,      0, 0, 1,  1, 0,      0, 7, 1, 'h3F));
    vecs.push_back(mk(0, 0,      1, 0, 1,  1, W_ADD2, 1, 7, 0, 0));
    vecs.push_back(mk(0, 0,      0, 0, 0,  1, 0,      0, 8, 0, 0));
    // Fill behind a stalled ADD, then NOP stream with push+pop; counter wraps 15->0
    vecs.push_back(mk(1, W_ADD,    1, 1, 0,  1, 0,        0, 8,  0, 0));
    vecs.push_back(mk(1, nop_w(1), 1, 1, 0,  1, 0,        0, 8,  0, 0));
    vecs.push_back(mk(1, nop_w(2), 1, 1, 0,  1, W_ADD,    0, 8,  0, 0));
    vecs.push_back(mk(1, nop_w(3), 1, 1, 0,  1, W_ADD,    0, 8,  0, 0));
    vecs.push_back(mk(1, nop_w(4), 1, 1, 0,  1, W_ADD,    0, 8,  0, 0));
    vecs.push_back(mk(1, nop_w(5), 1, 1, 0,  0, W_ADD,    0, 8,  0, 0));
    vecs.push_back(mk(1, nop_w(5), 0, 0, 0,  0, W_ADD,    1, 8,  0, 0));
    vecs.push_back(mk(1, nop_w(5), 0, 0, 0,  1, nop_w(1), 1, 9,  0, 0));
    vecs.push_back(mk(1, nop_w(6), 0, 0, 0,  1, nop_w(2), 1, 10, 0, 0));
    vecs.push_back(mk(0, 0,        0, 0, 0,  1, nop_w(3), 1, 11, 0, 0));
    vecs.push_back(mk(0, 0,        0, 0, 0,  1, nop_w(4), 1, 12, 0, 0));
    vecs.push_back(mk(0, 0,        0, 0, 0,  1, nop_w(5), 1, 13, 0, 0));
    vecs.push_back(mk(1, nop_w(7), 0, 0, 0,  1, nop_w(6), 1, 14, 0, 0));
    vecs.push_back(mk(0, 0,        0, 0, 0,  1, 0,        0, 15, 0, 0));
    vecs.push_back(mk(0, 0,        0, 0, 0,  1, nop_w(7), 1, 15, 0, 0));
    vecs.push_back(mk(0, 0,        0, 0, 0,  1, 0,        0, 0,  0, 0));

    // Power-on reset
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs("por", 1'b1, 32'h0, 1'b0, 4'd0, 1'b0, 6'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].v, vecs[i].instr, vecs[i].ack, vecs[i].busy, vecs[i].clr);
      @(negedge clk);
      check_outputs($sformatf("vec%0d", i), vecs[i].rdy, vecs[i].ew, vecs[i].ret,
                    vecs[i].cnt, vecs[i].trap, vecs[i].top);
      step();
    end

    // Mid-traffic asynchronous reset while an ADD is stalled and a NOP is queued
    drive(1'b1, nop_w(1), 1'b1, 1'b0, 1'b0); step();
    drive(1'b1, W_ADD,    1'b1, 1'b0, 1'b0); step();
    drive(1'b1, nop_w(2), 1'b1, 1'b0, 1'b0); step();
    drive(1'b0, 32'h0,    1'b1, 1'b1, 1'b0); step();
    check_outputs("stall_before_rst", 1'b1, W_ADD, 1'b0, 4'd1, 1'b0, 6'h0);
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs("async_rst", 1'b1, 32'h0, 1'b0, 4'd0, 1'b0, 6'h0);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b1;
    step();
    check_outputs("post_rst_1", 1'b1, 32'h0, 1'b0, 4'd0, 1'b0, 6'h0);
    step();
    check_outputs("post_rst_2", 1'b1, 32'h0, 1'b0, 4'd0, 1'b0, 6'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
